// File: rtl/homeostat_resource_if.sv
// Request/status bundle between a resource regulator (master) and the homeostat block (slave).
interface homeostat_resource_if #(
    parameter int W = 8
);
    logic         inc;
    logic         dec;
    logic         fast;
    logic         setval;
    logic [W-1:0] value;
    logic [1:0]   state;
    logic         hungry;
    logic         starving;
    logic         critical;

    modport master (
        output inc, dec, fast, setval,
        input  value, state, hungry, starving, critical
    );

    modport slave (
        input  inc, dec, fast, setval,
        output value, state, hungry, starving, critical
    );
endinterface

// File: rtl/homeostat_resource.sv
// Single saturating resource with periodic decay, hysteretic need FSM and starvation watchdog.
//   state    | meaning
//   SATED    | value comfortably above the hunger threshold
//   HUNGRY   | value below HUNGRY_TH, not yet back above HUNGRY_TH+HYST
//   STARVING | value below STARVE_TH; starvation counter runs
module homeostat_resource #(
    parameter int W            = 8,
    parameter int DEFAULT_VAL  = 128,
    parameter int SET_VAL      = 128,
    parameter int FAST_STEP    = 4,
    parameter int DECAY_PERIOD = 16,
    parameter int HUNGRY_TH    = 128,
    parameter int STARVE_TH    = 64,
    parameter int HYST         = 8,
    parameter int CRIT_CYCLES  = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    homeostat_resource_if.slave    bus
);

    localparam int VMAX   = (1 << W) - 1;
    localparam int PW     = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int CW     = $clog2(CRIT_CYCLES + 1);
    localparam int H_EXIT = HUNGRY_TH + HYST;
    localparam int S_EXIT = STARVE_TH + HYST;
    localparam bit H_OK   = (H_EXIT <= VMAX);
    localparam bit S_OK   = (S_EXIT <= VMAX);

    typedef enum logic [1:0] {
        SATED    = 2'b00,
        HUNGRY   = 2'b01,
        STARVING = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    logic [PW-1:0]         r_presc;
    logic                  w_decay_tick;
    logic [W-1:0]          r_value;
    logic [W-1:0]          w_value_nxt;
    logic signed [W+1:0]   w_step;
    logic signed [W+1:0]   w_delta;
    logic signed [W+1:0]   w_sum;
    logic signed [31:0]    w_val;
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_hungry;
    logic                  r_starving;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_critical;

    assign w_decay_tick = (DECAY_PERIOD != 0) && (r_presc == PW'(DECAY_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_decay_tick || (DECAY_PERIOD == 0)) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Signed W+2-bit sum: bit W+1 flags underflow, bit W flags overflow.
    always_comb begin
        w_step  = bus.fast ? (W+2)'(FAST_STEP) : (W+2)'(1);
        w_delta = '0;
        if (bus.inc && !bus.dec) begin
            w_delta = w_step;
        end else if (bus.dec && !bus.inc) begin
            w_delta = -w_step;
        end
        if (w_decay_tick) begin
            w_delta = w_delta - (W+2)'(1);
        end
        w_sum = $signed({2'b00, r_value}) + w_delta;

        if (bus.setval) begin
            w_value_nxt = W'(SET_VAL);
        end else if (w_sum[W+1]) begin
            w_value_nxt = '0;
        end else if (w_sum[W]) begin
            w_value_nxt = '1;
        end else begin
            w_value_nxt = w_sum[W-1:0];
        end
    end

    assign w_val = 32'(r_value);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SATED: begin
                if (w_val < STARVE_TH) begin
                    w_state_nxt = STARVING;
                end else if (w_val < HUNGRY_TH) begin
                    w_state_nxt = HUNGRY;
                end
            end
            HUNGRY: begin
                if (w_val < STARVE_TH) begin
                    w_state_nxt = STARVING;
                end else if (H_OK && (w_val >= H_EXIT)) begin
                    w_state_nxt = SATED;
                end
            end
            STARVING: begin
                if (H_OK && (w_val >= H_EXIT)) begin
                    w_state_nxt = SATED;
                end else if (S_OK && (w_val >= S_EXIT)) begin
                    w_state_nxt = HUNGRY;
                end
            end
            default: w_state_nxt = SATED;
        endcase
    end

    // Counter follows the registered state, so critical drops one clock after leaving STARVING.
    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == STARVING) begin
            if (r_cnt == CW'(CRIT_CYCLES)) begin
                w_cnt_nxt = r_cnt;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= W'(DEFAULT_VAL);
            r_state    <= SATED;
            r_hungry   <= 1'b0;
            r_starving <= 1'b0;
            r_cnt      <= '0;
            r_critical <= 1'b0;
        end else begin
            r_value    <= w_value_nxt;
            r_state    <= w_state_nxt;
            r_hungry   <= (w_state_nxt != SATED);
            r_starving <= (w_state_nxt == STARVING);
            r_cnt      <= w_cnt_nxt;
            r_critical <= (w_cnt_nxt == CW'(CRIT_CYCLES));
        end
    end

    assign bus.value    = r_value;
    assign bus.state    = r_state;
    assign bus.hungry   = r_hungry;
    assign bus.starving = r_starving;
    assign bus.critical = r_critical;

endmodule

// File: tb/tb_homeostat_resource.sv
// Bench for homeostat_resource: a default instance (decay on) and a no-decay, short-critical instance.
module tb_homeostat_resource;

    logic clk;
    logic rst_n;
    logic t_inc, t_dec, t_fast, t_setval;

    homeostat_resource_if #(.W(8)) ifa ();
    homeostat_resource_if #(.W(8)) ifb ();

    assign ifa.inc = t_inc;  assign ifa.dec = t_dec;  assign ifa.fast = t_fast;  assign ifa.setval = t_setval;
    assign ifb.inc = t_inc;  assign ifb.dec = t_dec;  assign ifb.fast = t_fast;  assign ifb.setval = t_setval;

    homeostat_resource #(.DECAY_PERIOD(16), .CRIT_CYCLES(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    homeostat_resource #(.DECAY_PERIOD(0), .CRIT_CYCLES(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int per [2] = '{16, 0};
    int crit[2] = '{255, 10};
    int mv[2], ms[2], mcnt[2], mcrit[2], mcyc[2];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 128; ms[k] = 0; mcnt[k] = 0; mcrit[k] = 0; mcyc[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit i, input bit d, input bit f, input bit s);
        int  nv, ns, nc, step;
        bit  tick;
        tick = (per[k] == 0) ? 1'b0 : ((mcyc[k] % per[k]) == per[k] - 1);
        mcyc[k]++;
        step = f ? 4 : 1;
        if (s) nv = 128;
        else begin
            nv = mv[k];
            if (i && !d) nv += step;
            if (d && !i) nv -= step;
            if (tick)    nv -= 1;
            if (nv < 0)   nv = 0;
            if (nv > 255) nv = 255;
        end
        ns = ms[k];
        if (ms[k] == 0) begin
            if (mv[k] < 64) ns = 2; else if (mv[k] < 128) ns = 1;
        end else if (ms[k] == 1) begin
            if (mv[k] < 64) ns = 2; else if (mv[k] >= 136) ns = 0;
        end else begin
            if (mv[k] >= 136) ns = 0; else if (mv[k] >= 72) ns = 1;
        end
        nc = (ms[k] == 2) ? ((mcnt[k] + 1 > crit[k]) ? crit[k] : mcnt[k] + 1) : 0;
        mv[k] = nv; ms[k] = ns; mcnt[k] = nc; mcrit[k] = (nc == crit[k]);
    endtask

    task automatic cmp_models();
        chk("a_value",    int'(ifa.value),    mv[0]);
        chk("a_state",    int'(ifa.state),    ms[0]);
        chk("a_hungry",   int'(ifa.hungry),   int'(ms[0] != 0));
        chk("a_starving", int'(ifa.starving), int'(ms[0] == 2));
        chk("a_critical", int'(ifa.critical), mcrit[0]);
        chk("b_value",    int'(ifb.value),    mv[1]);
        chk("b_state",    int'(ifb.state),    ms[1]);
        chk("b_hungry",   int'(ifb.hungry),   int'(ms[1] != 0));
        chk("b_starving", int'(ifb.starving), int'(ms[1] == 2));
        chk("b_critical", int'(ifb.critical), mcrit[1]);
    endtask

    task automatic step(input bit i, input bit d, input bit f, input bit s);
        t_inc = i; t_dec = d; t_fast = f; t_setval = s;
        @(posedge clk);
        #1;
        model_step(0, i, d, f, s);
        model_step(1, i, d, f, s);
        cmp_models();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_value"}, int'(ifa.value), 128);
        chk({tag, "_a_state"}, int'(ifa.state), 0);
        chk({tag, "_a_flags"}, int'({ifa.hungry, ifa.starving, ifa.critical}), 0);
        chk({tag, "_b_value"}, int'(ifb.value), 128);
        chk({tag, "_b_state"}, int'(ifb.state), 0);
        chk({tag, "_b_flags"}, int'({ifb.hungry, ifb.starving, ifb.critical}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int rep;
        bit inc, dec, fast, setval;
        int exp_v;
        int exp_st;
        int exp_crit;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n = 1'b1;
        t_inc = 0; t_dec = 0; t_fast = 0; t_setval = 0;
        model_reset();

        // Hand-derived trajectory for the no-decay instance (CRIT_CYCLES=10).
        tbl.push_back('{1,  0,1,0,0, 127, 1'b0 ? 1 : 0, 0});
        tbl.push_back('{1,  0,0,0,0, 127, 1, 0});
        tbl.push_back('{1,  1,0,0,0, 128, 1, 0});
        tbl.push_back('{1,  1,0,1,0, 132, 1, 0});
        tbl.push_back('{1,  1,0,1,0, 136, 1, 0});
        tbl.push_back('{1,  0,0,0,0, 136, 0, 0});
        tbl.push_back('{18, 0,1,1,0,  64, 1, 0});
        tbl.push_back('{1,  0,1,1,0,  60, 1, 0});
        tbl.push_back('{1,  0,0,0,0,  60, 2, 0});
        tbl.push_back('{9,  0,0,0,0,  60, 2, 0});
        tbl.push_back('{1,  0,0,0,0,  60, 2, 1});
        tbl.push_back('{5,  0,0,0,0,  60, 2, 1});
        tbl.push_back('{3,  1,0,1,0,  72, 2, 1});
        tbl.push_back('{1,  0,0,0,0,  72, 1, 1});
        tbl.push_back('{1,  0,0,0,0,  72, 1, 0});
        tbl.push_back('{1,  0,0,0,1, 128, 1, 0});
        tbl.push_back('{31, 1,0,1,0, 252, 0, 0});
        tbl.push_back('{2,  1,0,0,0, 254, 0, 0});
        tbl.push_back('{1,  1,0,1,0, 255, 0, 0});
        tbl.push_back('{1,  1,0,0,0, 255, 0, 0});
        tbl.push_back('{1,  0,0,0,1, 128, 0, 0});
        tbl.push_back('{31, 0,1,1,0,   4, 2, 1});
        tbl.push_back('{2,  0,1,0,0,   2, 2, 1});
        tbl.push_back('{1,  0,1,1,0,   0, 2, 1});
        tbl.push_back('{1,  0,1,0,0,   0, 2, 1});
        tbl.push_back('{1,  0,1,0,1, 128, 2, 1});
        tbl.push_back('{1,  0,0,0,0, 128, 1, 1});
        tbl.push_back('{1,  0,0,0,0, 128, 1, 0});

        // Decay timing on the default instance.
        do_reset();
        repeat (16) step(0, 0, 0, 0);
        chk("decay16_value", int'(ifa.value), 127);
        chk("decay16_state", int'(ifa.state), 0);
        step(0, 0, 0, 0);
        chk("decay17_hungry", int'(ifa.hungry), 1);
        repeat (15) step(0, 0, 0, 0);
        chk("decay32_value", int'(ifa.value), 126);

        // Vector table.
        do_reset();
        foreach (tbl[n]) begin
            for (int r = 0; r < tbl[n].rep; r++)
                step(tbl[n].inc, tbl[n].dec, tbl[n].fast, tbl[n].setval);
            chk($sformatf("tbl%0d_value", n), int'(ifb.value), tbl[n].exp_v);
            chk($sformatf("tbl%0d_state", n), int'(ifb.state), tbl[n].exp_st);
            chk($sformatf("tbl%0d_crit", n),  int'(ifb.critical), tbl[n].exp_crit);
        end

        // Simultaneous events against the decay tick on the default instance.
        do_reset();
        repeat (7) step(0, 1, 1, 0);
        repeat (8) step(0, 0, 0, 0);
        chk("pre_tick_value", int'(ifa.value), 100);
        step(1, 1, 0, 0);
        chk("incdec_tick_value", int'(ifa.value), 99);
        repeat (12) step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("pre_set_value", int'(ifa.value), 50);
        step(0, 1, 0, 1);
        chk("set_tick_value", int'(ifa.value), 128);
        chk("set_tick_state", int'(ifa.state), 2);
        step(0, 0, 0, 0);
        chk("after_set_state", int'(ifa.state), 1);
        chk("after_set_starving", int'(ifa.starving), 0);

        // Randomized phase with alternating up/down bias and an async reset mid-run.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit up;
            up = ((i / 80) % 2) == 1;
            step(up ? ($urandom % 4 != 0) : ($urandom % 4 == 0),
                 up ? ($urandom % 4 == 0) : ($urandom % 4 != 0),
                 ($urandom % 2) == 1,
                 ($urandom % 60) == 0);
            if (i == 333) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_reset_vals("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
